// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared widths, FSM state type and count-width helper for the systolic engine
package sa_pkg;
   localparam int SA_ROWS       = 8;
   localparam int SA_COLS       = 8;
   localparam int SA_DATA_WIDTH = 16;
   localparam int SA_ACC_WIDTH  = 32;
   localparam int SA_K_MAX      = 1024;

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, UNLOAD} state_e;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/sa_pe.sv
// rtl/sa_pe.sv - one processing element: registered operand pass-through and signed MAC
module sa_pe #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] a_in,
   input  logic signed [DATA_WIDTH-1:0] b_in,
   output logic signed [DATA_WIDTH-1:0] a_out,
   output logic signed [DATA_WIDTH-1:0] b_out,
   output logic signed [ACC_WIDTH-1:0]  acc
);
   localparam int PW = 2 * DATA_WIDTH;

   logic signed [PW-1:0] prod;

   assign prod = PW'(a_in) * PW'(b_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (clr) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (en) begin
         a_out <= a_in;
         b_out <= b_in;
         // sign-extended product, wrapping add
         acc   <= acc + ACC_WIDTH'(prod);
      end
   end
endmodule

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - output-stationary systolic C = A x B with skew, FSM and streaming handshakes
// SYSTOLIC_MM_RELU_EN clamps negative results to 0 at the output mux.
module systolic_mm_engine
   import sa_pkg::*;
#(
   parameter int ROWS       = SA_ROWS,
   parameter int COLS       = SA_COLS,
   parameter int DATA_WIDTH = SA_DATA_WIDTH,
   parameter int ACC_WIDTH  = SA_ACC_WIDTH,
   parameter int K_MAX      = SA_K_MAX
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [$clog2(K_MAX+1)-1:0]   k_len,
   output logic                         busy,
   output logic                         done,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ROWS*DATA_WIDTH-1:0]   a_vec,
   input  logic [COLS*DATA_WIDTH-1:0]   b_vec,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(ROWS)-1:0]      out_row_idx,
   output logic [COLS*ACC_WIDTH-1:0]    out_row
);
   localparam int KW         = $clog2(K_MAX + 1);
   localparam int IW         = $clog2(ROWS);
   localparam int DRAIN_CYC  = ROWS + COLS - 2;
   localparam int DRAIN_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
   localparam int CW         = cnt_width((K_MAX > DRAIN_CYC) ? K_MAX : DRAIN_CYC);

   if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc
      $error("systolic_mm_engine: ACC_WIDTH must be at least 2*DATA_WIDTH");
   end

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [KW-1:0]   k_q;
   logic [IW-1:0]   row_idx_q;
   logic            done_q;
   logic            step, clr, out_hs, last_row, last_beat, last_drain;

   logic signed [DATA_WIDTH-1:0] a_edge  [ROWS];
   logic signed [DATA_WIDTH-1:0] b_edge  [COLS];
   logic signed [DATA_WIDTH-1:0] pe_a_in [ROWS][COLS];
   logic signed [DATA_WIDTH-1:0] pe_b_in [ROWS][COLS];
   logic signed [DATA_WIDTH-1:0] a_h     [ROWS][COLS];
   logic signed [DATA_WIDTH-1:0] b_v     [ROWS][COLS];
   logic signed [ACC_WIDTH-1:0]  acc     [ROWS][COLS];

   assign busy        = (state_q != IDLE);
   assign in_ready    = (state_q == FEED);
   assign out_valid   = (state_q == UNLOAD);
   assign done        = done_q;
   assign out_row_idx = row_idx_q;

   assign step       = ((state_q == FEED) && in_valid) || (state_q == DRAIN);
   assign clr        = (state_q == IDLE) && start;
   assign out_hs     = out_valid && out_ready;
   assign last_row   = (row_idx_q == IW'(ROWS - 1));
   assign last_beat  = (cnt_q + CW'(1) == CW'(k_q));
   assign last_drain = (cnt_q == CW'(DRAIN_LAST));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (k_len == '0) ? UNLOAD : FEED;
         FEED:    if (in_valid && last_beat) state_d = (DRAIN_CYC == 0) ? UNLOAD : DRAIN;
         DRAIN:   if (last_drain) state_d = UNLOAD;
         UNLOAD:  if (out_hs && last_row) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         k_q       <= '0;
         row_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= out_hs && last_row;
         if (clr) k_q <= k_len;
         // counter restarts on every state change, so it serves both beat and drain counting
         if (state_d != state_q) cnt_q <= '0;
         else if (step)          cnt_q <= cnt_q + CW'(1);
         if (out_hs) row_idx_q <= last_row ? '0 : row_idx_q + IW'(1);
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
      logic signed [DATA_WIDTH-1:0] a_src;
      assign a_src = (state_q == FEED) ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (i == 0) begin : g_direct
         assign a_edge[i] = a_src;
      end else begin : g_chain
         logic signed [DATA_WIDTH-1:0] sk [i];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n || clr) begin
               for (int t = 0; t < i; t++) sk[t] <= '0;
            end else if (step) begin
               sk[0] <= a_src;
               for (int t = 1; t < i; t++) sk[t] <= sk[t-1];
            end
         end
         assign a_edge[i] = sk[i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_b_skew
      logic signed [DATA_WIDTH-1:0] b_src;
      assign b_src = (state_q == FEED) ? b_vec[j*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (j == 0) begin : g_direct
         assign b_edge[j] = b_src;
      end else begin : g_chain
         logic signed [DATA_WIDTH-1:0] sk [j];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n || clr) begin
               for (int t = 0; t < j; t++) sk[t] <= '0;
            end else if (step) begin
               sk[0] <= b_src;
               for (int t = 1; t < j; t++) sk[t] <= sk[t-1];
            end
         end
         assign b_edge[j] = sk[j-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         if (j == 0) begin : g_a_edge
            assign pe_a_in[i][j] = a_edge[i];
         end else begin : g_a_pass
            assign pe_a_in[i][j] = a_h[i][j-1];
         end
         if (i == 0) begin : g_b_edge
            assign pe_b_in[i][j] = b_edge[j];
         end else begin : g_b_pass
            assign pe_b_in[i][j] = b_v[i-1][j];
         end
         sa_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (step),
            .a_in  (pe_a_in[i][j]),
            .b_in  (pe_b_in[i][j]),
            .a_out (a_h[i][j]),
            .b_out (b_v[i][j]),
            .acc   (acc[i][j])
         );
      end
   end

   function automatic logic [ACC_WIDTH-1:0] out_elem(input logic signed [ACC_WIDTH-1:0] v);
`ifdef SYSTOLIC_MM_RELU_EN
      return v[ACC_WIDTH-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   always_comb begin
      out_row = '0;
      if (state_q == UNLOAD)
         for (int j = 0; j < COLS; j++)
            out_row[j*ACC_WIDTH +: ACC_WIDTH] = out_elem(acc[row_idx_q][j]);
   end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - self-checking bench: vector table, matrix reference model, handshake corner cases
module tb_systolic_mm_engine;
   localparam int R  = 8;
   localparam int C  = 8;
   localparam int DW = 16;
   localparam int AW = 32;
   localparam int KT = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [10:0]     k_len = '0;
   logic            busy, done, in_ready, out_valid;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [R*DW-1:0] a_vec = '0;
   logic [C*DW-1:0] b_vec = '0;
   logic [2:0]      out_row_idx;
   logic [C*AW-1:0] out_row;

   int n_cmp = 0;
   int n_bad = 0;
   int a_m   [R][KT];
   int b_m   [KT][C];
   int c_exp [R][C];

   typedef struct {
      int a_val;
      int b_val;
      int k;
      int exp_elem;
   } vec_t;
   vec_t tbl [7];

   systolic_mm_engine u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .k_len       (k_len),
      .busy        (busy),
      .done        (done),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a_vec       (a_vec),
      .b_vec       (b_vec),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row_idx (out_row_idx),
      .out_row     (out_row)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int relu32(input int v);
`ifdef SYSTOLIC_MM_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic clear_mats();
      for (int i = 0; i < R; i++) for (int k = 0; k < KT; k++) a_m[i][k] = 0;
      for (int k = 0; k < KT; k++) for (int j = 0; j < C; j++) b_m[k][j] = 0;
      for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) c_exp[i][j] = 0;
   endtask

   // Plain matrix product with 32-bit wraparound.
   task automatic model(input int k);
      longint s;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) s += longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
            c_exp[i][j] = int'(s);
         end
   endtask

   task automatic set_test1();
      clear_mats();
      a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
      b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
      c_exp[0][0] = 19; c_exp[0][1] = 22; c_exp[1][0] = 43; c_exp[1][1] = 50;
   endtask

   task automatic run_job(input int k, input int in_pct, input int out_pct, input bit hold, input string name);
      int beats, cyc, lat, rows;
      bit ir_bad, saw_done, took, stable;
      logic [255:0] held_row, er;
      logic [2:0]   held_idx;
      start = 1'b1;
      k_len = 11'(k);
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1; beats = 0; cyc = 0; ir_bad = 1'b0; saw_done = 1'b0;
      while (beats < k && cyc < 1000) begin
         in_valid = ($urandom_range(99) < in_pct);
         for (int i = 0; i < R; i++) a_vec[i*DW +: DW] = a_m[i][beats][15:0];
         for (int j = 0; j < C; j++) b_vec[j*DW +: DW] = b_m[beats][j][15:0];
         if (!in_ready) ir_bad = 1'b1;
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took) beats++;
         if (done) saw_done = 1'b1;
         cyc++; lat++;
      end
      in_valid = 1'b0; a_vec = '0; b_vec = '0;
      chk({name, "_beats"}, beats, k);
      cyc = 0;
      while (!out_valid && cyc < 1000) begin
         if (in_ready) ir_bad = 1'b1;
         if (done) saw_done = 1'b1;
         @(posedge clk); #1;
         cyc++; lat++;
      end
      chk({name, "_out_valid"}, out_valid, 1);
      if (in_pct == 100 && k > 0) chk({name, "_latency"}, lat, k + R + C - 1);
      if (hold) begin
         held_row = out_row; held_idx = out_row_idx; out_ready = 1'b0; stable = 1'b1;
         for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            k_len = 11'd3;
            @(posedge clk); #1;
            start = 1'b0;
            if (out_row !== held_row || out_row_idx !== held_idx || !out_valid || done || !busy) stable = 1'b0;
         end
         chk({name, "_hold_stable"}, stable, 1);
      end
      rows = 0; cyc = 0;
      while (rows < R && cyc < 1000) begin
         out_ready = ($urandom_range(99) < out_pct);
         if (in_ready) ir_bad = 1'b1;
         if (done) saw_done = 1'b1;
         if (out_valid && out_ready) begin
            er = '0;
            for (int j = 0; j < C; j++) er[j*AW +: AW] = relu32(c_exp[rows][j]);
            chk($sformatf("%s_idx%0d", name, rows), out_row_idx, rows);
            chk($sformatf("%s_row%0d", name, rows), out_row, er);
            rows++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      chk({name, "_rows"}, rows, R);
      chk({name, "_in_ready_only_feed"}, ir_bad, 0);
      chk({name, "_no_early_done"}, saw_done, 0);
      chk({name, "_done_pulse"}, done, 1);
      chk({name, "_idle_busy"}, busy, 0);
      @(posedge clk); #1;
      chk({name, "_done_one_cycle"}, done, 0);
      chk({name, "_stays_idle"}, {busy, out_valid}, 2'b00);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_idx", out_row_idx, 0);
      chk("rst_row", out_row, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      set_test1();
      run_job(2, 100, 100, 0, "t1");

      tbl[0] = '{1, 2, 2, 4};
      tbl[1] = '{-32768, -32768, 2, 32'sh8000_0000};
      tbl[2] = '{32767, 32767, 3, -1073938429};
      tbl[3] = '{32767, -32768, 4, 131072};
      tbl[4] = '{-1, 1, 5, -5};
      tbl[5] = '{7, -3, 1, -21};
      tbl[6] = '{5, 5, 0, 0};
      for (int t = 0; t < 7; t++) begin
         for (int i = 0; i < R; i++) for (int k = 0; k < KT; k++) a_m[i][k] = tbl[t].a_val;
         for (int k = 0; k < KT; k++) for (int j = 0; j < C; j++) b_m[k][j] = tbl[t].b_val;
         for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) c_exp[i][j] = tbl[t].exp_elem;
         run_job(tbl[t].k, 100, (t % 2 == 1) ? 50 : 100, 0, $sformatf("tbl%0d", t));
      end

      clear_mats();
      for (int i = 0; i < R; i++) a_m[i][i] = 1;
      for (int k = 0; k < R; k++)
         for (int j = 0; j < C; j++) begin
            b_m[k][j] = $signed(16'($urandom));
            c_exp[k][j] = b_m[k][j];
         end
      run_job(8, 100, 100, 0, "ident");
      run_job(8, 50, 100, 0, "ident_stall");

      for (int n = 0; n < 5; n++) begin
         int k;
         k = $urandom_range(KT, 1);
         clear_mats();
         for (int i = 0; i < R; i++) for (int kk = 0; kk < k; kk++) a_m[i][kk] = $signed(16'($urandom));
         for (int kk = 0; kk < k; kk++) for (int j = 0; j < C; j++) b_m[kk][j] = $signed(16'($urandom));
         model(k);
         run_job(k, 60, 60, (n == 0), $sformatf("rnd%0d", n));
      end

      for (int i = 0; i < R; i++) for (int k = 0; k < KT; k++) a_m[i][k] = 32767;
      start = 1'b1; k_len = 11'd4;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      a_vec = {R{16'sh7fff}};
      b_vec = {C{16'sh8000}};
      repeat (2) begin @(posedge clk); #1; end
      chk("abort_in_feed", in_ready, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_out_valid", out_valid, 0);
      in_valid = 1'b0; a_vec = '0; b_vec = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
      set_test1();
      run_job(2, 100, 100, 0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
Parametrised output-stationary systolic matrix-multiply engine: computes C[ROWS][COLS] = A[ROWS][K] x B[K][COLS] for runtime K.
- Contains internal input-skew registers, a feed/drain/unload FSM and valid/ready streaming on input and output.
- Sits between the operand stream buffers and the result writeback path.
- Supersedes the fixed 8x8 array, which had no control, skew or handshake.

Parameters:
ROWS, 8, PE rows (A vector length, number of output rows)
COLS, 8, PE columns (B vector length, output row length)
DATA_WIDTH, 16, signed operand width
ACC_WIDTH, 32, signed accumulator width
K_MAX, 1024, largest supported inner dimension

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle job request, sampled in IDLE only
k_len  in  $clog2(K_MAX+1)  inner dimension K, sampled with start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last output row handshake
in_valid  in  1  operand beat valid
in_ready  out  1  high only in FEED
a_vec  in  ROWS*DATA_WIDTH  column k of A; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
b_vec  in  COLS*DATA_WIDTH  row k of B; element j packed the same way
out_valid  out  1  result row valid
out_ready  in  1  result row accepted
out_row_idx  out  $clog2(ROWS)  index of the presented row
out_row  out  COLS*ACC_WIDTH  C[out_row_idx][0..COLS-1], packed like a_vec

Behaviour:
- Reset (async assert, sync release): FSM to IDLE; all skew registers, PE operand registers and accumulators to 0; busy, done, in_ready, out_valid 0; out_row_idx 0; out_row 0.
- FSM states: IDLE, FEED, DRAIN, UNLOAD.
- IDLE: on start with k_len>0, latch K, clear all accumulators and skew/PE registers, go to FEED next cycle.
- IDLE, start with k_len==0: clear accumulators, go directly to UNLOAD; all outputs read 0.
- start outside IDLE is ignored.
- FEED:
  - Each accepted beat (in_valid & in_ready) advances the whole array one step: skew chains shift, PE operand registers shift, each PE accumulates.
  - No beat means the array holds: no shift, no accumulate.
  - After K accepted beats, go to DRAIN.
- Skew: row i of A delayed i steps, column j of B delayed j steps. A[i][k] meets B[k][j] at PE(i,j) on step k+i+j.
- PE step: acc <= acc + a_in*b_in; a_out <= a_in; b_out <= b_in.
- DRAIN: advances every cycle with zeros injected at the skew inputs, for exactly ROWS+COLS-2 cycles, then UNLOAD. Skip DRAIN when ROWS+COLS-2 == 0.
- UNLOAD:
  - out_valid high; out_row presents row out_row_idx, starting at 0.
  - On handshake, increment out_row_idx.
  - After the handshake on row ROWS-1: pulse done, return to IDLE, reset out_row_idx to 0.
  - With out_ready low, out_row and out_row_idx stay stable.
- Arithmetic: the full-precision 2*DATA_WIDTH signed product is sign-extended to ACC_WIDTH, then added modulo 2^ACC_WIDTH (wrap, no saturation). Requires ACC_WIDTH >= 2*DATA_WIDTH; elaboration error otherwise.
- Latency: with no stalls, first out_valid occurs 1+K+ROWS+COLS-2 cycles after the start cycle.
- Reset mid-job: all state is lost; no done pulse.
- Accumulators are static outside FEED/DRAIN.

Optional Feature:
SYSTOLIC_MM_RELU_EN:
- Defined: each out_row element is max(acc,0) (negative values read 0), applied combinationally at the output mux only; accumulators are unaffected.
- Undefined: raw signed accumulators are output.

Decomposition:
- Package sa_pkg: default width constants and a localparam function for the count width.
- Package typedef state_e {IDLE, FEED, DRAIN, UNLOAD}.
- One sub-module, sa_pe (one PE with step enable and sync clear), instantiated ROWS x COLS in a generate loop. Skew chains and the FSM stay in the top module.

Test Plan:
1. ROWS=COLS=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], no stalls -> rows [19,22] then [43,50]; first out_valid 5 cycles after start; done pulse after 2nd handshake.
2. Default 8x8, K=8, A=identity, B=random int16 -> C equals B bit-exact. Repeat with in_valid toggling randomly 50% -> same result, in_ready high only in FEED.
3. A all -32768, B all -32768, K=2 -> every element 2^31 wraps to -2147483648. With SYSTOLIC_MM_RELU_EN defined -> 0.
4. out_ready held low 10 cycles in UNLOAD -> out_row_idx and out_row stable, no done. Second start during UNLOAD is ignored.
5. k_len=0 -> no FEED beats accepted; ROWS zero rows are output; done asserted.
6. rst_n asserted mid-FEED -> busy, in_ready and out_valid drop immediately. A new job after release with K=2, the values of test 1 -> correct results with no residue from the aborted job.
